// File: rtl/lmsm_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_expand_seq
//  Purpose  : Decode-stage sequencer for a 2-wide pipeline. Passes ordinary
//             instruction pairs straight through. Expands LM/SM instructions
//             into single-register LW/SW micro-ops, at most two per cycle.
//             While an expansion is running it holds the residual LM/SM and
//             any trailing fetched instruction, and stalls fetch. All outputs
//             are registered behind a valid/ready handshake to dispatch.
//  Revision : 1.0 - initial release
// ============================================================================
module lmsm_expand_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] in_I0,
  input  logic [15:0] in_I1,
  input  logic        in_V0,
  input  logic        in_V1,
  input  logic [15:0] in_PC0,
  input  logic [15:0] in_PC1,
  input  logic        out_ready,
  output logic [15:0] out_I0,
  output logic [15:0] out_I1,
  output logic        out_V0,
  output logic        out_V1,
  output logic [15:0] out_PC0,
  output logic [15:0] out_PC1,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_TAIL   = 2'd2
  } state_t;

  localparam logic [2:0] C_LMSM_OP = 3'b011;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic is_lmsm(input logic [15:0] ins);
    return ins[15:13] == C_LMSM_OP;
  endfunction

  // Index of the lowest set bit; only meaningful for a nonzero mask.
  function automatic logic [2:0] lsb_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Mask bit k selects register 7-k; LM becomes LW (0100), SM becomes SW (0101).
  function automatic logic [15:0] mk_uop(input logic       sm,
                                         input logic [2:0] base,
                                         input logic [2:0] k,
                                         input logic [5:0] imm);
    return {2'b01, 1'b0, sm, 3'd7 - k, base, imm};
  endfunction

  // --------------------------------------------------------------------------
  // State and holding registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;

  // Residual LM/SM: only the fields the micro-op encoding needs are kept.
  logic        r_res_sm;
  logic [2:0]  r_res_base;
  logic [7:0]  r_res_mask;
  logic [15:0] r_res_pc;
  logic [5:0]  r_res_imm;

  logic [15:0] r_tail_i;
  logic        r_tail_v;
  logic [15:0] r_tail_pc;

  logic        w_res_sm_nxt;
  logic [2:0]  w_res_base_nxt;
  logic [7:0]  w_res_mask_nxt;
  logic [15:0] w_res_pc_nxt;
  logic [5:0]  w_res_imm_nxt;
  logic [15:0] w_tail_i_nxt;
  logic        w_tail_v_nxt;
  logic [15:0] w_tail_pc_nxt;

  logic [15:0] w_out_i0_nxt;
  logic [15:0] w_out_i1_nxt;
  logic        w_out_v0_nxt;
  logic        w_out_v1_nxt;
  logic [15:0] w_out_pc0_nxt;
  logic [15:0] w_out_pc1_nxt;

  // --------------------------------------------------------------------------
  // Handshake and source pair
  // --------------------------------------------------------------------------
  logic        w_adv;
  logic [15:0] w_s0_i;
  logic        w_s0_v;
  logic [15:0] w_s0_pc;
  logic [15:0] w_s1_i;
  logic        w_s1_v;
  logic [15:0] w_s1_pc;

  // The output stage can move when dispatch takes it or when it is empty.
  assign w_adv = out_ready | ~(out_V0 | out_V1);

  assign fetch_stall = ~((r_state == S_IDLE) & w_adv & ~flush);

  // In TAIL the held trailing instruction becomes the lone source in slot 0.
  always_comb begin
    w_s0_i  = in_I0;
    w_s0_v  = in_V0;
    w_s0_pc = in_PC0;
    w_s1_i  = in_I1;
    w_s1_v  = in_V1;
    w_s1_pc = in_PC1;
    if (r_state == S_TAIL) begin
      w_s0_i  = r_tail_i;
      w_s0_v  = r_tail_v;
      w_s0_pc = r_tail_pc;
      w_s1_i  = 16'h0000;
      w_s1_v  = 1'b0;
      w_s1_pc = 16'h0000;
    end
  end

  // Slot classification: a zero-mask LM/SM is treated as an empty slot.
  logic       w_s0_ok;
  logic       w_s1_ok;
  logic       w_s0_lm;
  logic       w_s1_lm;
  logic [7:0] w_s0_rest1;
  logic [7:0] w_s0_rest2;
  logic [7:0] w_s1_rest1;
  logic [7:0] w_r_rest1;
  logic [7:0] w_r_rest2;
  logic [5:0] w_imm_a;
  logic [5:0] w_imm_b;

  assign w_s0_ok = w_s0_v & ~(is_lmsm(w_s0_i) & (w_s0_i[7:0] == 8'h00));
  assign w_s1_ok = w_s1_v & ~(is_lmsm(w_s1_i) & (w_s1_i[7:0] == 8'h00));
  assign w_s0_lm = w_s0_ok & is_lmsm(w_s0_i);
  assign w_s1_lm = w_s1_ok & is_lmsm(w_s1_i);

  // Clearing the lowest set bit, once or twice, yields what is left to emit.
  assign w_s0_rest1 = w_s0_i[7:0] & (w_s0_i[7:0] - 8'd1);
  assign w_s0_rest2 = w_s0_rest1 & (w_s0_rest1 - 8'd1);
  assign w_s1_rest1 = w_s1_i[7:0] & (w_s1_i[7:0] - 8'd1);
  assign w_r_rest1  = r_res_mask & (r_res_mask - 8'd1);
  assign w_r_rest2  = w_r_rest1 & (w_r_rest1 - 8'd1);

  // res_imm holds the offset of the last emitted micro-op.
  assign w_imm_a = r_res_imm + 6'd2;
  assign w_imm_b = r_res_imm + 6'd4;

  // --------------------------------------------------------------------------
  // Next-state, next-output and holding-register logic
  // --------------------------------------------------------------------------
  // Computes what the next advancing edge loads; everything holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_res_sm_nxt   = r_res_sm;
    w_res_base_nxt = r_res_base;
    w_res_mask_nxt = r_res_mask;
    w_res_pc_nxt   = r_res_pc;
    w_res_imm_nxt  = r_res_imm;
    w_tail_i_nxt   = r_tail_i;
    w_tail_v_nxt   = r_tail_v;
    w_tail_pc_nxt  = r_tail_pc;
    w_out_i0_nxt   = 16'h0000;
    w_out_i1_nxt   = 16'h0000;
    w_out_v0_nxt   = 1'b0;
    w_out_v1_nxt   = 1'b0;
    w_out_pc0_nxt  = 16'h0000;
    w_out_pc1_nxt  = 16'h0000;

    case (r_state)
      S_EXPAND: begin
        // Continue the residual: one or two more micro-ops.
        w_out_v0_nxt  = 1'b1;
        w_out_i0_nxt  = mk_uop(r_res_sm, r_res_base, lsb_idx(r_res_mask), w_imm_a);
        w_out_pc0_nxt = r_res_pc;
        if (w_r_rest1 != 8'h00) begin
          w_out_v1_nxt  = 1'b1;
          w_out_i1_nxt  = mk_uop(r_res_sm, r_res_base, lsb_idx(w_r_rest1), w_imm_b);
          w_out_pc1_nxt = r_res_pc;
        end
        w_res_mask_nxt = w_r_rest2;
        if (w_r_rest2 != 8'h00) begin
          w_state_nxt   = S_EXPAND;
          w_res_imm_nxt = w_imm_b;
        end else if (r_tail_v) begin
          w_state_nxt = S_TAIL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        if (w_s0_lm) begin
          // Older slot is LM/SM: start expanding it, park slot 1 as the tail.
          w_out_v0_nxt  = 1'b1;
          w_out_i0_nxt  = mk_uop(w_s0_i[12], w_s0_i[11:9], lsb_idx(w_s0_i[7:0]), 6'd0);
          w_out_pc0_nxt = w_s0_pc;
          if (w_s0_rest1 != 8'h00) begin
            w_out_v1_nxt  = 1'b1;
            w_out_i1_nxt  = mk_uop(w_s0_i[12], w_s0_i[11:9], lsb_idx(w_s0_rest1), 6'd2);
            w_out_pc1_nxt = w_s0_pc;
          end
          w_tail_i_nxt   = w_s1_i;
          w_tail_v_nxt   = w_s1_ok;
          w_tail_pc_nxt  = w_s1_pc;
          w_res_sm_nxt   = w_s0_i[12];
          w_res_base_nxt = w_s0_i[11:9];
          w_res_mask_nxt = w_s0_rest2;
          w_res_pc_nxt   = w_s0_pc;
          w_res_imm_nxt  = 6'd2;
          if (w_s0_rest2 != 8'h00) begin
            w_state_nxt = S_EXPAND;
          end else if (w_s1_ok) begin
            w_state_nxt = S_TAIL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          // Slot 0 passes through; slot 1 passes or starts an expansion.
          w_out_v0_nxt  = w_s0_ok;
          w_out_i0_nxt  = w_s0_ok ? w_s0_i  : 16'h0000;
          w_out_pc0_nxt = w_s0_ok ? w_s0_pc : 16'h0000;
          w_tail_v_nxt  = 1'b0;
          w_state_nxt   = S_IDLE;
          if (w_s1_lm) begin
            w_out_v1_nxt   = 1'b1;
            w_out_i1_nxt   = mk_uop(w_s1_i[12], w_s1_i[11:9], lsb_idx(w_s1_i[7:0]), 6'd0);
            w_out_pc1_nxt  = w_s1_pc;
            w_res_sm_nxt   = w_s1_i[12];
            w_res_base_nxt = w_s1_i[11:9];
            w_res_mask_nxt = w_s1_rest1;
            w_res_pc_nxt   = w_s1_pc;
            w_res_imm_nxt  = 6'd0;
            if (w_s1_rest1 != 8'h00) begin
              w_state_nxt = S_EXPAND;
            end
          end else begin
            w_out_v1_nxt  = w_s1_ok;
            w_out_i1_nxt  = w_s1_ok ? w_s1_i  : 16'h0000;
            w_out_pc1_nxt = w_s1_ok ? w_s1_pc : 16'h0000;
          end
        end
      end
    endcase
  end

  // State register: flush returns to IDLE, otherwise moves only on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (w_adv) begin
      r_state <= w_state_nxt;
    end
  end

  // Output and holding registers: flush drops valids, stall freezes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_I0     <= 16'h0000;
      out_I1     <= 16'h0000;
      out_V0     <= 1'b0;
      out_V1     <= 1'b0;
      out_PC0    <= 16'h0000;
      out_PC1    <= 16'h0000;
      r_res_sm   <= 1'b0;
      r_res_base <= 3'd0;
      r_res_mask <= 8'h00;
      r_res_pc   <= 16'h0000;
      r_res_imm  <= 6'd0;
      r_tail_i   <= 16'h0000;
      r_tail_v   <= 1'b0;
      r_tail_pc  <= 16'h0000;
    end else if (flush) begin
      out_V0   <= 1'b0;
      out_V1   <= 1'b0;
      r_tail_v <= 1'b0;
    end else if (w_adv) begin
      out_I0     <= w_out_i0_nxt;
      out_I1     <= w_out_i1_nxt;
      out_V0     <= w_out_v0_nxt;
      out_V1     <= w_out_v1_nxt;
      out_PC0    <= w_out_pc0_nxt;
      out_PC1    <= w_out_pc1_nxt;
      r_res_sm   <= w_res_sm_nxt;
      r_res_base <= w_res_base_nxt;
      r_res_mask <= w_res_mask_nxt;
      r_res_pc   <= w_res_pc_nxt;
      r_res_imm  <= w_res_imm_nxt;
      r_tail_i   <= w_tail_i_nxt;
      r_tail_v   <= w_tail_v_nxt;
      r_tail_pc  <= w_tail_pc_nxt;
    end
  end

endmodule
`default_nettype wire
